// File: rtl/sd_photo_seq.sv
// SD-card image read sequencer: walks the sectors of stored images and issues
// one read request per sector, with per-sector timeout/retry and LOOP/ONESHOT modes.
module sd_photo_seq #(
    parameter int unsigned IMG_NUM      = 4,
    parameter int unsigned IMG_W        = 2,
    parameter logic [31:0] BASE_ADDR    = 32'd8256,
    parameter logic [31:0] IMG_STRIDE   = 32'd1216,
    parameter int unsigned SEC_NUM      = 1200,
    parameter int unsigned SEC_W        = 11,
    parameter int unsigned DELAY_CYCLES = 50_000_000,
    parameter int unsigned DLY_W        = 26,
    parameter int unsigned TMO_CYCLES   = 1_000_000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic [IMG_W-1:0] img_sel,
    input  logic             rd_busy,
    output logic             rd_start_en,
    output logic [31:0]      rd_sec_addr,
    output logic [IMG_W-1:0] img_idx,
    output logic             img_done,
    output logic             seq_busy,
    output logic             err,
    output logic [7:0]       retry_cnt
);

    localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_NUM - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(IMG_NUM - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [IMG_W-1:0] img_q, img_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic [7:0]       retry_cnt_q, retry_cnt_d;
    logic             rd_start_en_q, rd_start_en_d;
    logic [31:0]      addr_q, addr_d;
    logic             img_done_q, img_done_d;
    logic             seq_busy_q, seq_busy_d;
    logic             err_q, err_d;
    logic             busy_d0_q, busy_d1_q;
    logic             neg_busy;

    // Busy falling edge, seen two clocks after rd_busy drops.
    assign neg_busy = busy_d1_q & ~busy_d0_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        img_d       = img_q;
        sec_d       = sec_q;
        dly_d       = dly_q;
        tmo_d       = tmo_q;
        rty_d       = rty_q;
        retry_cnt_d = retry_cnt_q;
        img_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && !mode) begin
                    mode_d  = 1'b0;
                    sec_d   = '0;
                    state_d = S_ISSUE;
                end else if (en && start && (32'(img_sel) < IMG_NUM)) begin
                    mode_d  = 1'b1;
                    img_d   = img_sel;
                    sec_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the same cycle as the timeout takes priority.
                if (neg_busy) begin
                    rty_d = '0;
                    if (sec_q == SEC_LAST) begin
                        img_done_d = 1'b1;
                        sec_d      = '0;
                        state_d    = mode_q ? S_IDLE : S_DELAY;
                    end else if (en) begin
                        sec_d   = sec_q + SEC_W'(1);
                        state_d = S_ISSUE;
                    end else begin
                        sec_d   = '0;
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    if (rty_q < RTY_MAX) begin
                        rty_d = rty_q + RTY_W'(1);
                        if (retry_cnt_q != 8'hFF) begin
                            retry_cnt_d = retry_cnt_q + 8'd1;
                        end
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DELAY: begin
                if (!en || (dly_q == DLY_LAST)) begin
                    dly_d   = '0;
                    img_d   = (img_q == IMG_LAST) ? '0 : img_q + IMG_W'(1);
                    state_d = en ? S_ISSUE : S_IDLE;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            S_ERROR: begin
                if (!en) begin
                    sec_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of the next state, so they line up with it.
        rd_start_en_d = (state_d == S_ISSUE);
        addr_d        = rd_start_en_d ? (BASE_ADDR + 32'(img_d) * IMG_STRIDE + 32'(sec_d))
                                      : addr_q;
        seq_busy_d    = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_DELAY);
        err_d         = (state_d == S_ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            img_q         <= '0;
            sec_q         <= '0;
            dly_q         <= '0;
            tmo_q         <= '0;
            rty_q         <= '0;
            retry_cnt_q   <= '0;
            rd_start_en_q <= 1'b0;
            addr_q        <= '0;
            img_done_q    <= 1'b0;
            seq_busy_q    <= 1'b0;
            err_q         <= 1'b0;
            busy_d0_q     <= 1'b0;
            busy_d1_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            img_q         <= img_d;
            sec_q         <= sec_d;
            dly_q         <= dly_d;
            tmo_q         <= tmo_d;
            rty_q         <= rty_d;
            retry_cnt_q   <= retry_cnt_d;
            rd_start_en_q <= rd_start_en_d;
            addr_q        <= addr_d;
            img_done_q    <= img_done_d;
            seq_busy_q    <= seq_busy_d;
            err_q         <= err_d;
            busy_d0_q     <= rd_busy;
            busy_d1_q     <= busy_d0_q;
        end
    end

    assign rd_start_en = rd_start_en_q;
    assign rd_sec_addr = addr_q;
    assign img_idx     = img_q;
    assign img_done    = img_done_q;
    assign seq_busy    = seq_busy_q;
    assign err         = err_q;
    assign retry_cnt   = retry_cnt_q;

endmodule
